fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side front end for the synchronous FIFO: drains the FIFO through its read-enable/empty interface and presents the words on a valid/ready stream. It hides the FIFO's one-cycle registered read latency behind a 2-entry output buffer, so a consumer sees a standard back-pressured stream at full throughput. It sits directly on the FIFO's read port and shares its clock and reset.

## Interface
- fifo_width, 8, data word width; must equal the FIFO's word width
- cnt_width, 16, width of the delivered-word counter; used only with FIFO_RD_COUNT_EN

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset; shared with the FIFO
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  fifo_width  FIFO data_out; valid in the cycle after an accepted read
- fifo_r_en  out  1  FIFO read enable
- m_valid  out  1  stream word valid
- m_ready  in  1  consumer ready
- m_data  out  fifo_width  stream word; the head of the buffer
- rd_count  out  cnt_width  words delivered; present only with FIFO_RD_COUNT_EN

## Operation
- Output buffer:
  - Two entries: slot0 is the head, slot1 is next.
  - Occupancy state occ takes the values EMPTY, ONE or TWO.
  - m_valid = (occ != EMPTY); m_data = slot0.
- inflight register:
  - Set to 1 on a clock edge where fifo_r_en = 1.
  - Otherwise set to 0.
  - Means fifo_data holds a fresh word this cycle.
- pop = m_valid && m_ready.
- Read issue is combinational: fifo_r_en = !rst && !fifo_empty && (occ + inflight - pop) < 2.
  - This guarantees no overflow.
  - There is a combinational path from m_ready to fifo_r_en.
- Next state: occ_next = occ + inflight - pop. It never exceeds TWO and never drops below EMPTY.
- Data movement, in the same edge:
  - On pop, slot1 shifts into slot0.
  - A landing word (inflight = 1) is written to slot index (occ - pop).
- Transitions:
  - EMPTY → ONE on landing.
  - ONE → TWO on landing without pop.
  - ONE → EMPTY on pop without landing.
  - ONE stays ONE on landing with pop.
  - TWO → ONE on pop; a landing in TWO cannot occur.
- Ordering: words leave in FIFO order. No word is dropped or duplicated.
- The FIFO itself guards r_en against empty. This block additionally never asserts fifo_r_en while fifo_empty = 1.

## Timing
- Reset values: occ = EMPTY, inflight = 0, slot0 = slot1 = 0, m_valid = 0, m_data = 0, fifo_r_en = 0, rd_count = 0.
- Latency: with fifo_r_en high in cycle T, the word is on fifo_data in T+1 and m_valid = 1 in T+2 (buffer was empty).
- Throughput: with m_ready held high and the FIFO non-empty, one word per cycle is sustained after the initial 2-cycle fill.
- Back-pressure:
  - m_valid and m_data stay stable while m_valid && !m_ready.
  - Reads stop once occ + inflight = 2.
- Simultaneous landing and pop in ONE: occupancy is unchanged; the new word becomes the head.
- FIFO goes empty mid-stream: buffered words still drain; fifo_r_en stays 0 until fifo_empty deasserts.
- Reset mid-operation:
  - Any in-flight word is discarded and the buffer is cleared.
  - The FIFO is reset by the same rst, so no words are lost inconsistently.
- m_ready may toggle in any cycle, independent of m_valid.

## Configuration
- FIFO_RD_COUNT_EN defined:
  - rd_count exists.
  - It increments by 1 on each pop and wraps modulo 2^cnt_width.
  - Reset value is 0.
- Undefined: the rd_count port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package fifo_rd_pkg holds the occupancy encoding: OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_TWO = 2'd2.
- One sub-module: fifo_rd_buf, the 2-entry buffer with occupancy FSM. It has ports for push (landing), pop, data in, head data and occ.
- The top level holds the issue logic, the inflight register and the optional counter.

## Test plan
- Reset: assert rst with FIFO holding 3 words → next cycle m_valid = 0, fifo_r_en = 0, m_data = 0, rd_count = 0.
- Streaming: FIFO holds 0x11, 0x22, 0x33, m_ready = 1 → fifo_r_en high for 3 cycles; m_data = 0x11, 0x22, 0x33 in consecutive cycles starting 2 cycles after the first read; then m_valid = 0.
- Back-pressure: 4 words, m_ready = 0 → exactly 2 reads issued; m_valid = 1 with m_data = first word held stable; raising m_ready → all 4 words delivered in order.
- Toggle: m_ready alternating 1/0 over 8 words → 8 words delivered in order, no duplicates, occ never exceeds TWO.
- Reset mid-stream: rst asserted while inflight = 1 and occ = ONE → next cycle m_valid = 0; post-reset writes 0xA5 → first delivered word is 0xA5.
- With FIFO_RD_COUNT_EN and cnt_width = 4: deliver 17 words → rd_count = 1.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Occupancy encoding and fill-level helper shared by the FIFO read front end.
// Optional rd_count feature (FIFO_RD_COUNT_EN) lives in the top level only.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam int unsigned BUF_DEPTH = 2;

  // Words that will be held or in flight after this edge, before any new read.
  function automatic logic [2:0] fill_after(input occ_t occ, input logic inflight, input logic pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Two-entry skid buffer behind the FIFO read port; a landing word is visible one edge later.
// Never refuses a landing: the caller only reads when a slot is guaranteed free.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_head_dat,
  output occ_t             o_occ,
  output logic             o_vld
);

  occ_t             r_occ;
  occ_t             w_occ_next;
  logic [WIDTH-1:0] r_slot0;
  logic [WIDTH-1:0] r_slot1;
  logic [WIDTH-1:0] w_slot0_next;
  logic [WIDTH-1:0] w_slot1_next;
  logic             w_pop;
  logic             w_land_idx;

  assign w_pop      = i_pop && (r_occ != OCC_EMPTY);
  assign o_vld      = (r_occ != OCC_EMPTY);
  assign o_head_dat = r_slot0;
  assign o_occ      = r_occ;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ <= OCC_EMPTY;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  always_comb begin
    w_occ_next = r_occ;
    case (r_occ)
      OCC_EMPTY: begin
        if (i_push) w_occ_next = OCC_ONE;
      end
      OCC_ONE: begin
        if (i_push && !w_pop)      w_occ_next = OCC_TWO;
        else if (!i_push && w_pop) w_occ_next = OCC_EMPTY;
      end
      OCC_TWO: begin
        if (w_pop) w_occ_next = OCC_ONE;
      end
      default: w_occ_next = OCC_EMPTY;
    endcase
  end

  // Shift first, then the landing word overrides slot (occ - pop).
  always_comb begin
    w_slot0_next = r_slot0;
    w_slot1_next = r_slot1;
    w_land_idx   = (r_occ == OCC_TWO) || ((r_occ == OCC_ONE) && !w_pop);
    if (w_pop) w_slot0_next = r_slot1;
    if (i_push) begin
      if (w_land_idx) w_slot1_next = i_dat;
      else            w_slot0_next = i_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      r_slot0 <= w_slot0_next;
      r_slot1 <= w_slot1_next;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO onto a valid/ready stream; first word valid 2 cycles after the read.
// Reads stop while buffered + in-flight words reach 2; FIFO_RD_COUNT_EN adds the rd_count port.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int fifo_width = 8
`ifdef FIFO_RD_COUNT_EN
  , parameter int cnt_width = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [fifo_width-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [fifo_width-1:0] m_data
`ifdef FIFO_RD_COUNT_EN
  , output logic [cnt_width-1:0] rd_count
`endif
);

  logic       r_inflight;
  logic       w_pop;
  logic [2:0] w_fill;
  occ_t       w_occ;

  assign w_pop  = m_valid && m_ready;
  assign w_fill = fill_after(w_occ, r_inflight, w_pop);

  // Combinational from m_ready so a pop frees a slot for a read in the same cycle.
  assign fifo_r_en = !rst && !fifo_empty && (w_fill < 3'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_r_en;
    end
  end

  fifo_rd_buf #(
    .WIDTH (fifo_width)
  ) u_buf (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (r_inflight),
    .i_pop      (w_pop),
    .i_dat      (fifo_data),
    .o_head_dat (m_data),
    .o_occ      (w_occ),
    .o_vld      (m_valid)
  );

`ifdef FIFO_RD_COUNT_EN
  logic [cnt_width-1:0] r_rd_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= '0;
    end else if (w_pop) begin
      r_rd_count <= r_rd_count + 1'b1;
    end
  end

  assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-backed FIFO model feeds the DUT and a scoreboard checks the stream.
// Build with FIFO_RD_COUNT_EN to also exercise rd_count at cnt_width = 4.
module tb_fifo_stream_reader;

  localparam int W = 8;
`ifdef FIFO_RD_COUNT_EN
  localparam int CW = 4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_r_en;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
`ifdef FIFO_RD_COUNT_EN
  logic [CW-1:0] rd_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mem [256];
  logic [7:0]   wr_ptr = '0;
  logic [7:0]   rd_ptr = '0;
  int           cyc = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];
  int           rd_cyc_q [$];
  int           dv_cyc_q [$];
  int           issued = 0, popped = 0, max_out = 0, hold_err = 0, empty_rd_err = 0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_dat = '0;

  fifo_stream_reader #(
    .fifo_width (W)
`ifdef FIFO_RD_COUNT_EN
    , .cnt_width (CW)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_RD_COUNT_EN
    , .rd_count (rd_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO with one-cycle registered read; reset flushes it.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
    end else if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      got_q.delete(); rd_cyc_q.delete(); dv_cyc_q.delete();
      issued = 0; popped = 0; max_out = 0; hold_err = 0; empty_rd_err = 0;
      prev_hold = 1'b0;
    end else begin
      if (fifo_r_en && fifo_empty) empty_rd_err++;
      if (prev_hold && (!m_valid || m_data !== prev_dat)) hold_err++;
      if (fifo_r_en) begin issued++; rd_cyc_q.push_back(cyc); end
      if (m_valid && m_ready) begin popped++; got_q.push_back(m_data); dv_cyc_q.push_back(cyc); end
      if (issued - popped > max_out) max_out = issued - popped;
      prev_hold = m_valid && !m_ready;
      prev_dat  = m_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(d);
  endtask

  task automatic apply_reset();
    rst = 1'b1; m_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_delivered(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin tick(1); k++; end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) push_word(8'(8'h40 + i));
    tick(4);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if (m_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    n_tests++; if (fifo_r_en !== 1'b0) begin n_fail++; $display("FAIL reset_r_en got=%b want=0", fifo_r_en); end
    n_tests++; if (m_data !== 8'h00)   begin n_fail++; $display("FAIL reset_m_data got=%h want=00", m_data); end
`ifdef FIFO_RD_COUNT_EN
    n_tests++; if (rd_count !== 4'd0)  begin n_fail++; $display("FAIL reset_rd_count got=%0d want=0", rd_count); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_streaming();
    apply_reset();
    m_ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    wait_delivered(3, 20);
    tick(2);
    n_tests++; if (got_q.size() != 3) begin n_fail++; $display("FAIL stream_count got=%0d want=3", got_q.size()); end
    n_tests++; if (rd_cyc_q.size() != 3) begin n_fail++; $display("FAIL stream_reads got=%0d want=3", rd_cyc_q.size()); end
    if (got_q.size() == 3 && rd_cyc_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        n_tests++;
        if (dv_cyc_q[i] != rd_cyc_q[0] + 2 + i) begin
          n_fail++; $display("FAIL stream_cycle[%0d] got=%0d want=%0d", i, dv_cyc_q[i], rd_cyc_q[0] + 2 + i);
        end
        n_tests++;
        if (rd_cyc_q[i] != rd_cyc_q[0] + i) begin n_fail++; $display("FAIL stream_read_cycle[%0d] got=%0d want=%0d", i, rd_cyc_q[i], rd_cyc_q[0] + i); end
      end
    end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle_valid got=%b want=0", m_valid); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    tick(8);
    n_tests++; if (issued != 2) begin n_fail++; $display("FAIL bp_reads got=%0d want=2", issued); end
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got=%b want=1", m_valid); end
    n_tests++; if (m_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_head got=%h want=%h", m_data, exp_q[0]); end
    n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_stable got=%0d want=0", hold_err); end
    m_ready = 1'b1;
    wait_delivered(4, 30);
    n_tests++; if (got_q.size() != 4) begin n_fail++; $display("FAIL bp_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_toggle();
    int k = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    while (got_q.size() < 8 && k < 80) begin
      m_ready = ~m_ready;
      tick(1); k++;
    end
    tick(2);
    n_tests++; if (got_q.size() != 8) begin n_fail++; $display("FAIL toggle_count got=%0d want=8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (max_out > 2) begin n_fail++; $display("FAIL toggle_occupancy got=%0d want<=2", max_out); end
    n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL toggle_stable got=%0d want=0", hold_err); end
  endtask

  task automatic test_random();
    int mism = 0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      m_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 45 && 8'(wr_ptr - rd_ptr) < 8'd200) push_word(8'($urandom));
      tick(1);
    end
    m_ready = 1'b1;
    wait_delivered(exp_q.size(), 400);
    tick(2);
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    n_tests++; if (mism != 0) begin n_fail++; $display("FAIL rand_order got=%0d mismatched words want=0", mism); end
    n_tests++; if (max_out > 2) begin n_fail++; $display("FAIL rand_occupancy got=%0d want<=2", max_out); end
    n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL rand_stable got=%0d want=0", hold_err); end
    n_tests++; if (empty_rd_err != 0) begin n_fail++; $display("FAIL rand_read_empty got=%0d want=0", empty_rd_err); end
`ifdef FIFO_RD_COUNT_EN
    n_tests++;
    if (rd_count !== CW'(popped)) begin n_fail++; $display("FAIL rand_rd_count got=%0d want=%0d", rd_count, CW'(popped)); end
`endif
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    m_ready = 1'b0;
    push_word(8'h5A); push_word(8'h6B);
    tick(2);
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b want=1", m_valid); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b want=0", m_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    push_word(8'hA5);
    m_ready = 1'b1;
    wait_delivered(1, 20);
    tick(3);
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL mid_count got=%0d want=1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_tests++; if (got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL mid_first got=%h want=a5", got_q[0]); end
    end
  endtask

`ifdef FIFO_RD_COUNT_EN
  task automatic test_count_wrap();
    apply_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(8'(i));
    wait_delivered(17, 60);
    tick(2);
    n_tests++; if (got_q.size() != 17) begin n_fail++; $display("FAIL cnt_words got=%0d want=17", got_q.size()); end
    n_tests++; if (rd_count !== 4'd1) begin n_fail++; $display("FAIL cnt_wrap got=%0d want=1", rd_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_toggle();
    test_reset_midstream();
    test_random();
`ifdef FIFO_RD_COUNT_EN
    test_count_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
